// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key-schedule engine:
//   - ks_state_t   : key-schedule controller state encoding
//   - SBOX_FLAT    : forward S-box, byte b at [2047-8*b -: 8]
//   - sbox()       : single-byte S-box lookup
//   - sub_word()   : SubWord, four S-box lookups on a 32-bit word
//   - rot_word()   : RotWord, cyclic left byte rotation
//   - rcon_word()  : places the round constant in the most significant byte
//   - xtime()      : multiply by x in GF(2^8), advances the round constant
//   - nk_legal()   : key-length legality check (Nk = 4, 6 or 8)
// Word convention: byte 0 of a FIPS-197 word is bits [31:24].
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon_word(input logic [7:0] rc);
    return {rc, 24'h000000};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic bit nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// ---------------------------------------------------------------------------
// aes_key_word_gen
// Combinational generator for one key-schedule word w[i] from w[i-Nk] and
// w[i-1]. Holds the only SubWord (4 S-box) instance of the engine; the
// RotWord/plain selection happens in front of it so it is shared by both
// the group-start and the Nk=8 mid-group cases.
// Ports:
//   i_w_prev  [31:0] : w[i-1]
//   i_w_back  [31:0] : w[i-Nk]
//   i_idx_mod [2:0]  : i mod Nk
//   i_rcon    [7:0]  : current round constant byte
//   o_word    [31:0] : w[i]
// ---------------------------------------------------------------------------
module aes_key_word_gen
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [31:0] i_w_prev,
  input  logic [31:0] i_w_back,
  input  logic [2:0]  i_idx_mod,
  input  logic [7:0]  i_rcon,
  output logic [31:0] o_word
);

  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;

  // Rotation is only needed at the start of an Nk group.
  assign w_sub_in  = (i_idx_mod == 3'd0) ? rot_word(i_w_prev) : i_w_prev;
  assign w_sub_out = sub_word(w_sub_in);

  always_comb begin
    o_word = i_w_back ^ i_w_prev;
    if (i_idx_mod == 3'd0) begin
      o_word = i_w_back ^ w_sub_out ^ rcon_word(i_rcon);
    end else if ((NK == 8) && (i_idx_mod == 3'd4)) begin
      o_word = i_w_back ^ w_sub_out;
    end
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_seq
// Sequential AES key expansion: one schedule word per cycle through a
// single shared SubWord path, all NW words held in a register array and
// served as 128-bit round keys through a registered read port.
// Handshake: a key is taken on a rising edge where i_key_valid and
// o_key_ready are both high; the source holds i_key_valid and i_key stable
// until that edge. i_key_valid while o_key_ready is low has no effect.
// Ports:
//   i_clk, i_reset         : clock, asynchronous active-high reset
//   i_key_valid/o_key_ready: key handshake; i_key word i at [32*i+:32]
//   o_busy                 : expansion in progress
//   o_keys_valid           : all NW words valid for the current key
//   i_rd_en, i_rd_round    : round-key read request (round 0..Nr)
//   o_rd_vld, o_rd_ok      : read valid (1-cycle latency), round complete
//   o_rd_rkey              : round key, word j at [32*j+:32]
//   o_state                : controller state, for observation
// ---------------------------------------------------------------------------
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NK = 4,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1),
  localparam int RW = $clog2(NR + 1),
  localparam int IW = $clog2(NW)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_key_valid,
  output logic            o_key_ready,
  input  logic [32*NK-1:0] i_key,
  output logic            o_busy,
  output logic            o_keys_valid,
  input  logic            i_rd_en,
  input  logic [RW-1:0]   i_rd_round,
  output logic            o_rd_vld,
  output logic            o_rd_ok,
  output logic [127:0]    o_rd_rkey,
  output ks_state_t       o_state
);

  if (!nk_legal(NK)) begin : g_bad_nk
    $error("aes_key_schedule_seq: NK must be 4, 6 or 8");
  end

  ks_state_t   r_state;
  logic [IW-1:0] r_idx;
  logic [2:0]  r_idx_mod;
  logic [7:0]  r_rcon;
  logic        r_keys_valid;
  logic        r_rd_vld;
  logic        r_rd_ok;
  logic [127:0] r_rd_rkey;
  logic [31:0] r_w [NW];

  logic          w_accept;
  logic [IW-1:0] w_back_idx;
  logic [IW-1:0] w_prev_idx;
  logic [31:0]   w_next;
  logic          w_rd_in_range;
  logic [IW-1:0] w_rd_base;
  logic [7:0]    w_rd_last;

  assign w_accept = i_key_valid && (r_state != ST_EXPAND);

  // Guard the look-back indices so idle-state reads stay inside the array.
  assign w_back_idx = (r_idx >= IW'(NK)) ? (r_idx - IW'(NK)) : '0;
  assign w_prev_idx = (r_idx != '0) ? (r_idx - IW'(1)) : '0;

  aes_key_word_gen #(.NK(NK)) u_word_gen (
    .i_w_prev  (r_w[w_prev_idx]),
    .i_w_back  (r_w[w_back_idx]),
    .i_idx_mod (r_idx_mod),
    .i_rcon    (r_rcon),
    .o_word    (w_next)
  );

  // Controller.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_idx_mod    <= 3'd0;
      r_rcon       <= 8'h01;
      r_keys_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_READY: begin
          if (i_key_valid) begin
            r_state      <= ST_EXPAND;
            r_idx        <= IW'(NK);
            r_idx_mod    <= 3'd0;
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (r_idx_mod == 3'd0) begin
            r_rcon <= xtime(r_rcon);
          end
          r_idx_mod <= (r_idx_mod == 3'(NK - 1)) ? 3'd0 : (r_idx_mod + 3'd1);
          if (r_idx == IW'(NW - 1)) begin
            r_state      <= ST_READY;
            r_keys_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Word storage: enabled flops, intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int i = 0; i < NK; i++) begin
        r_w[i] <= i_key[32*i +: 32];
      end
    end else if (r_state == ST_EXPAND) begin
      r_w[r_idx] <= w_next;
    end
  end

  // Read port. A round is complete once its last word index is below idx.
  assign w_rd_in_range = (i_rd_round <= RW'(NR));
  assign w_rd_base     = w_rd_in_range ? IW'({i_rd_round, 2'b00}) : '0;
  assign w_rd_last     = 8'({i_rd_round, 2'b11});

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_vld  <= 1'b0;
      r_rd_ok   <= 1'b0;
      r_rd_rkey <= '0;
    end else begin
      r_rd_vld <= i_rd_en;
      r_rd_ok  <= w_rd_in_range &&
                  ((r_state == ST_READY) || (w_rd_last < 8'(r_idx)));
      for (int j = 0; j < 4; j++) begin
        r_rd_rkey[32*j +: 32] <= r_w[w_rd_base + IW'(j)];
      end
    end
  end

  assign o_key_ready  = (r_state != ST_EXPAND);
  assign o_busy       = (r_state == ST_EXPAND);
  assign o_keys_valid = r_keys_valid;
  assign o_rd_vld     = r_rd_vld;
  assign o_rd_ok      = r_rd_ok;
  assign o_rd_rkey    = r_rd_rkey;
  assign o_state      = r_state;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule_seq
// Directed bench for the sequential AES key schedule: three instances
// (Nk = 4, 6, 8) driven from one linear sequence, FIPS-197 Appendix A keys,
// expected values hand-computed from the standard.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule_seq;
  import aes_pkg::*;

  localparam logic [127:0] KEY_A1    = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
  localparam logic [127:0] RK1_A1    = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
  localparam logic [127:0] RK10_A1   = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
  localparam logic [127:0] RK10_ZERO = 128'h6f8f188e_23e951cf_3e92e211_b4ef5bcb;
  localparam logic [191:0] KEY_A2 =
    192'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
  localparam logic [255:0] KEY_A3 =
    256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;

  // Clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Nk = 4 instance
  logic         k4_key_valid, k4_key_ready, k4_busy, k4_keys_valid;
  logic [127:0] k4_key;
  logic         k4_rd_en, k4_rd_vld, k4_rd_ok;
  logic [3:0]   k4_rd_round;
  logic [127:0] k4_rd_rkey;
  ks_state_t    k4_state;

  aes_key_schedule_seq #(.NK(4)) dut4 (
    .i_clk(clk), .i_reset(rst),
    .i_key_valid(k4_key_valid), .o_key_ready(k4_key_ready), .i_key(k4_key),
    .o_busy(k4_busy), .o_keys_valid(k4_keys_valid),
    .i_rd_en(k4_rd_en), .i_rd_round(k4_rd_round),
    .o_rd_vld(k4_rd_vld), .o_rd_ok(k4_rd_ok), .o_rd_rkey(k4_rd_rkey),
    .o_state(k4_state)
  );

  // Nk = 6 instance
  logic         k6_key_valid, k6_key_ready, k6_busy, k6_keys_valid;
  logic [191:0] k6_key;
  logic         k6_rd_en, k6_rd_vld, k6_rd_ok;
  logic [3:0]   k6_rd_round;
  logic [127:0] k6_rd_rkey;
  ks_state_t    k6_state;

  aes_key_schedule_seq #(.NK(6)) dut6 (
    .i_clk(clk), .i_reset(rst),
    .i_key_valid(k6_key_valid), .o_key_ready(k6_key_ready), .i_key(k6_key),
    .o_busy(k6_busy), .o_keys_valid(k6_keys_valid),
    .i_rd_en(k6_rd_en), .i_rd_round(k6_rd_round),
    .o_rd_vld(k6_rd_vld), .o_rd_ok(k6_rd_ok), .o_rd_rkey(k6_rd_rkey),
    .o_state(k6_state)
  );

  // Nk = 8 instance
  logic         k8_key_valid, k8_key_ready, k8_busy, k8_keys_valid;
  logic [255:0] k8_key;
  logic         k8_rd_en, k8_rd_vld, k8_rd_ok;
  logic [3:0]   k8_rd_round;
  logic [127:0] k8_rd_rkey;
  ks_state_t    k8_state;

  aes_key_schedule_seq #(.NK(8)) dut8 (
    .i_clk(clk), .i_reset(rst),
    .i_key_valid(k8_key_valid), .o_key_ready(k8_key_ready), .i_key(k8_key),
    .o_busy(k8_busy), .o_keys_valid(k8_keys_valid),
    .i_rd_en(k8_rd_en), .i_rd_round(k8_rd_round),
    .o_rd_vld(k8_rd_vld), .o_rd_ok(k8_rd_ok), .o_rd_rkey(k8_rd_rkey),
    .o_state(k8_state)
  );

  int total;
  int bad;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ticks after the accept edge until keys_valid is seen (bounded).
  task automatic wait_kv4(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!k4_keys_valid && n < 200);
  endtask

  task automatic load4(input logic [127:0] key);
    k4_key       = key;
    k4_key_valid = 1'b1;
    tick();
    k4_key_valid = 1'b0;
  endtask

  task automatic read4(input logic [3:0] round);
    k4_rd_en    = 1'b1;
    k4_rd_round = round;
    tick();
    k4_rd_en    = 1'b0;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    k4_key_valid = 1'b0; k4_key = '0; k4_rd_en = 1'b0; k4_rd_round = '0;
    k6_key_valid = 1'b0; k6_key = '0; k6_rd_en = 1'b0; k6_rd_round = '0;
    k8_key_valid = 1'b0; k8_key = '0; k8_rd_en = 1'b0; k8_rd_round = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_key_ready",  k4_key_ready,  1'b1);
    chk("rst_busy",       k4_busy,       1'b0);
    chk("rst_keys_valid", k4_keys_valid, 1'b0);
    chk("rst_rd_vld",     k4_rd_vld,     1'b0);
    chk("rst_rd_ok",      k4_rd_ok,      1'b0);
    chk("rst_rd_rkey",    k4_rd_rkey,    128'h0);
    chk("rst_state",      128'(k4_state), 128'(ST_IDLE));
    rst = 1'b0;
    tick();

    // A.1 expansion, latency and last round key
    load4(KEY_A1);
    chk("a1_busy",      k4_busy,      1'b1);
    chk("a1_key_ready", k4_key_ready, 1'b0);
    wait_kv4(n);
    chk("a1_latency",   128'(n),      128'd40);
    chk("a1_ready_kr",  k4_key_ready, 1'b1);
    chk("a1_ready_st",  128'(k4_state), 128'(ST_READY));
    read4(4'd10);
    chk("a1_r10_vld",  k4_rd_vld,  1'b1);
    chk("a1_r10_ok",   k4_rd_ok,   1'b1);
    chk("a1_r10_rkey", k4_rd_rkey, RK10_A1);
    read4(4'd11);
    chk("a1_r11_ok",   k4_rd_ok,   1'b0);
    tick();
    chk("idle_rd_vld", k4_rd_vld,  1'b0);

    // Reload A.1 from READY; partial reads and an ignored key pulse
    load4(KEY_A1);
    chk("reload_kv_drop", k4_keys_valid, 1'b0);
    read4(4'd0);
    chk("r0_early_ok",   k4_rd_ok,   1'b1);
    chk("r0_early_rkey", k4_rd_rkey, KEY_A1);
    k4_rd_en     = 1'b1;
    k4_rd_round  = 4'd1;
    k4_key       = '0;
    k4_key_valid = 1'b1;
    tick();
    chk("r1_idx5_ok", k4_rd_ok, 1'b0);
    k4_key_valid = 1'b0;
    tick();
    chk("r1_idx6_ok", k4_rd_ok, 1'b0);
    tick();
    chk("r1_idx7_ok", k4_rd_ok, 1'b0);
    tick();
    chk("r1_idx8_ok",   k4_rd_ok,   1'b1);
    chk("r1_idx8_rkey", k4_rd_rkey, RK1_A1);
    k4_rd_en = 1'b0;
    wait_kv4(n);
    chk("ign_kv", k4_keys_valid, 1'b1);
    read4(4'd10);
    chk("ign_r10_rkey", k4_rd_rkey, RK10_A1);

    // Reset in the middle of expansion (idx = 20)
    load4(KEY_A1);
    repeat (16) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_key_ready",  k4_key_ready,  1'b1);
    chk("mid_rst_busy",       k4_busy,       1'b0);
    chk("mid_rst_keys_valid", k4_keys_valid, 1'b0);
    chk("mid_rst_rd_ok",      k4_rd_ok,      1'b0);
    chk("mid_rst_rd_rkey",    k4_rd_rkey,    128'h0);
    chk("mid_rst_state",      128'(k4_state), 128'(ST_IDLE));
    rst = 1'b0;
    tick();
    load4(KEY_A1);
    wait_kv4(n);
    chk("post_rst_latency", 128'(n), 128'd40);

    // Back-to-back: zero key accepted in the first READY cycle, with a
    // simultaneous read that must see the A.1 contents
    k4_key       = '0;
    k4_key_valid = 1'b1;
    k4_rd_en     = 1'b1;
    k4_rd_round  = 4'd10;
    tick();
    k4_key_valid = 1'b0;
    k4_rd_en     = 1'b0;
    chk("b2b_busy",    k4_busy,       1'b1);
    chk("b2b_kv",      k4_keys_valid, 1'b0);
    chk("b2b_pre_ok",  k4_rd_ok,      1'b1);
    chk("b2b_pre_rk",  k4_rd_rkey,    RK10_A1);
    wait_kv4(n);
    chk("zero_latency", 128'(n), 128'd40);
    read4(4'd10);
    chk("zero_r10_rkey", k4_rd_rkey, RK10_ZERO);

    // Nk = 6, A.2
    k6_key       = KEY_A2;
    k6_key_valid = 1'b1;
    tick();
    k6_key_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!k6_keys_valid && n < 200);
    chk("a2_latency", 128'(n), 128'd46);
    k6_rd_en    = 1'b1;
    k6_rd_round = 4'd12;
    tick();
    k6_rd_en    = 1'b0;
    chk("a2_r12_ok",  k6_rd_ok,            1'b1);
    chk("a2_w51",     k6_rd_rkey[127:96],  32'h01002202);

    // Nk = 8, A.3
    k8_key       = KEY_A3;
    k8_key_valid = 1'b1;
    tick();
    k8_key_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!k8_keys_valid && n < 200);
    chk("a3_latency", 128'(n), 128'd52);
    k8_rd_en    = 1'b1;
    k8_rd_round = 4'd14;
    tick();
    k8_rd_en    = 1'b0;
    chk("a3_r14_ok",  k8_rd_ok,            1'b1);
    chk("a3_w59",     k8_rd_rkey[127:96],  32'h706c631e);
    k8_rd_en    = 1'b1;
    k8_rd_round = 4'd15;
    tick();
    k8_rd_en    = 1'b0;
    chk("a3_r15_ok",  k8_rd_ok,            1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Sequential, parametrised AES key expansion engine. Accepts a 128/192/256-bit cipher key over a valid/ready handshake and generates the 4*(Nr+1) schedule words at one word per cycle through a single shared SubWord path (4 S-boxes). It stores the words internally and serves any round key through a registered read port. It is the area-reduced successor to the fully unrolled expansion and feeds the iterative cipher/inverse-cipher datapaths.

## Interface
- Nk, default 4: key length in 32-bit words; legal values 4, 6, 8 (elaboration error otherwise)
- Nr, default Nk+6: number of rounds; derived, not overridden
- NW, default 4*(Nr+1): total schedule words (44/52/60)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  key present on `key`
- key_ready  out  1  engine can accept a key
- key  in  32*Nk  cipher key; word i = key[32*i+:32]
- busy  out  1  expansion in progress
- keys_valid  out  1  all NW words valid for the current key
- rd_en  in  1  round-key read request
- rd_round  in  $clog2(Nr+1)  round index 0..Nr
- rd_vld  out  1  read data valid (rd_en delayed 1 cycle)
- rd_ok  out  1  requested round was fully computed at request time
- rd_rkey  out  128  round key; word j = w[4*rd_round+j] at [32*j+:32]

## Operation
- States: IDLE, EXPAND, READY (enum in aes_pkg).
- key_ready = 1 in IDLE and READY, 0 in EXPAND. Accept = key_valid & key_ready.
- IDLE/READY + accept: write w[0..Nk-1] <= key words, idx <= Nk, rcon <= 0x01, keys_valid <= 0 -> EXPAND.
- EXPAND: each cycle write w[idx] from w[idx-Nk] and w[idx-1]:
  - idx%Nk==0: w[idx-Nk] ^ SubWord(RotWord(w[idx-1])) ^ {rcon,24'h0} (byte placement per aes_pkg RCON convention); then rcon <= xtime(rcon).
  - Nk==8 && idx%Nk==4: w[idx-Nk] ^ SubWord(w[idx-1]).
  - else: w[idx-Nk] ^ w[idx-1].
  - idx==NW-1: -> READY, keys_valid <= 1; otherwise idx <= idx+1.
- key_valid during EXPAND is ignored (not queued). The source holds it until key_ready.
- Read: rd_rkey <= w[4*rd_round +: 4]; rd_ok <= (state==READY) | (4*rd_round+3 < idx). Reads are legal in any state. rd_round > Nr gives rd_ok=0 and rd_rkey unspecified.
- Simultaneous accept and rd_en: the read returns the pre-accept contents and rd_ok reflects the pre-accept state.
- Word storage is not reset. All control state and outputs are reset.

## Timing
- Reset values: state=IDLE, key_ready=1, busy=0, keys_valid=0, rd_vld=0, rd_ok=0, rd_rkey=0, idx=0, rcon=0x01.
- Accept at edge T: busy=1 from T+1. w[idx] is written at edges T+1..T+NW-Nk.
- keys_valid=1 and key_ready=1 from cycle T+NW-Nk+1. Latency is 40 / 46 / 52 cycles for Nk=4/6/8.
- Round 0 is readable with rd_ok=1 the cycle after accept (also covers Nk>=4 words).
- Read latency 1 cycle. rd_vld/rd_ok/rd_rkey update every cycle; rd_vld=0 when no request.
- Reset asserted mid-EXPAND: immediate return to IDLE, keys_valid=0. After release the first accepted key restarts from idx=Nk.
- A new key accepted in READY drops keys_valid at the next edge. Back-to-back keys incur no idle cycle.

## Structure
- aes_pkg additions: state enum typedef, xtime() function, localparam legal-Nk check. SubWord, RotWord and RCON reused from aes_pkg.
- Sub-module aes_key_word_gen (combinational): inputs w_prev, w_back, idx_mod (position within Nk group), rcon, Nk parameter; output next word. Contains the single 4-S-box instance.
- Storage: NW x 32 register array written via `DFFEN`-style enabled flops; control via reset flops.

## Test plan
- Nk=4, FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> keys_valid after 40 cycles. Round 10 read gives w40..w43 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- Nk=6, A.2 key 8e73b0f7…522c6b7b -> keys_valid after 46 cycles, w51 = 01002202. Nk=8, A.3 key 603deb10…0914dff4 -> after 52 cycles, w59 = 706c631e.
- Read round 1 mid-EXPAND (Nk=4, idx=6) -> rd_ok=0. Same read at idx>=8 -> rd_ok=1 with w4..w7 = a0fafe17 88542cb1 23a33939 2a6c7605.
- key_valid pulsed with a different key during EXPAND -> ignored; final round keys match the first key.
- Reset asserted at idx=20 -> outputs return to reset values next cycle. A new A.1 load completes correctly in 40 cycles.
- Two keys back-to-back (A.1 then all-zero key) -> second accepted in the first READY cycle. For the zero key, w43 = b4ef5bcb (round 10 key b4ef5bcb3e92e21123e951cf6f8f188e).
